// File: rtl/drum_step_sequencer_if.sv
// Pattern write port between the UI pattern editor and the step sequencer.
// A beat transfers on a clk edge where wr_valid and wr_ready are both high.
interface drum_step_sequencer_if #(
    parameter int STEP_W = 4
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [STEP_W-1:0] wr_addr;
    logic [8:0]        wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/drum_step_sequencer.sv
// 16-step pattern sequencer feeding the square/impulse tone datapath.
// Each step: one LOAD cycle, then PLAY until the latched step length expires.
module drum_step_sequencer #(
    parameter int NUM_STEPS = 16,
    parameter int STEP_W    = 4,
    parameter int CNT_W     = 32,
    parameter int MIN_STEP  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [CNT_W-1:0]      step_cycles,
    input  logic [CNT_W-1:0]      gate_cycles,
    drum_step_sequencer_if.slave  wr,
    output logic [CNT_W-1:0]      wave_period,
    output logic                  trig,
    output logic                  gate,
    output logic [STEP_W-1:0]     step_idx,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY
    } state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] FLOOR = CNT_W'(MIN_STEP);

    state_t           state_q;
    state_t           state_d;
    logic [8:0]       pattern [NUM_STEPS];
    logic [8:0]       entry;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_l;
    logic [CNT_W-1:0] len_g;
    logic [CNT_W-1:0] l_in;
    logic [CNT_W-1:0] g_raw;
    logic [CNT_W-1:0] g_in;
    logic [CNT_W-1:0] period;
    logic             step_end;

    assign entry  = pattern[step_idx];
    assign period = CNT_W'({1'b1, entry[7:4], 2'b00}) << entry[3:0];

    // Gate is kept strictly shorter than the step so it always drops before LOAD.
    assign l_in  = (step_cycles < FLOOR) ? FLOOR : step_cycles;
    assign g_raw = (gate_cycles == '0) ? ONE : gate_cycles;
    assign g_in  = (g_raw > l_in - ONE) ? l_in - ONE : g_raw;

    assign wr.wr_ready = (state_q != LOAD);
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (cnt == len_l - TWO) begin
                    step_end = 1'b1;
                    state_d  = run ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pattern[i] <= '0;
            end
            cnt         <= '0;
            len_l       <= FLOOR;
            len_g       <= ONE;
            wave_period <= '0;
            trig        <= 1'b0;
            gate        <= 1'b0;
            step_idx    <= '0;
        end else begin
            if (wr.wr_valid && wr.wr_ready) begin
                pattern[wr.wr_addr] <= wr.wr_data;
            end
            trig <= 1'b0;
            case (state_q)
                LOAD: begin
                    len_l <= l_in;
                    len_g <= g_in;
                    cnt   <= '0;
                    trig  <= entry[8];
                    gate  <= entry[8];
                    if (entry[8]) begin
                        wave_period <= period;
                    end
                end
                PLAY: begin
                    cnt <= cnt + ONE;
                    if (cnt == len_g - ONE) begin
                        gate <= 1'b0;
                    end
                    if (step_end) begin
                        step_idx <= run ? step_idx + 1'b1 : '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Randomized scoreboard bench for drum_step_sequencer.
// Expected trig events are scheduled from the pattern and step timing rules.
module tb_drum_step_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] step_cycles = '0;
    logic [31:0] gate_cycles = '0;
    logic [31:0] wave_period;
    logic        trig;
    logic        gate;
    logic [3:0]  step_idx;
    logic        busy;

    drum_step_sequencer_if wif ();

    drum_step_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .step_cycles (step_cycles),
        .gate_cycles (gate_cycles),
        .wr          (wif),
        .wave_period (wave_period),
        .trig        (trig),
        .gate        (gate),
        .step_idx    (step_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint      cyc;
        logic [31:0] wp;
        logic [3:0]  idx;
        int          g;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [8:0]  model_pat [16];
    logic [31:0] exp_wp;
    longint      cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          gate_run = 0;
    int          gcount = 0;
    int          gexp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] tone_period(logic [8:0] e);
        longint p;
        p = longint'(64 + 4 * int'(e[7:4])) << e[3:0];
        return p[31:0];
    endfunction

    function automatic int step_len(int sc);
        return (sc < 2) ? 2 : sc;
    endfunction

    function automatic int gate_len(int gc, int l);
        int g;
        g = (gc < 1) ? 1 : gc;
        if (g > l - 1) g = l - 1;
        return g;
    endfunction

    // Monitor: pops one expectation per trig and times the gate pulse.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            gate_run = 0;
        end else begin
            if (gate_run) begin
                if (gate) begin
                    gcount++;
                end else begin
                    chk("gate_len", gcount, gexp);
                    gate_run = 0;
                end
            end else if (gate && !trig) begin
                chk("stray_gate", gate, 0);
            end
            if (trig) begin
                if (sb.size() == 0) begin
                    chk("stray_trig", trig, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("trig_cycle", cyc, mon_e.cyc);
                    chk("trig_period", wave_period, mon_e.wp);
                    chk("trig_idx", step_idx, mon_e.idx);
                    chk("gate_at_trig", gate, 1);
                    gate_run = 1;
                    gcount = 1;
                    gexp = mon_e.g;
                end
            end
        end
    end

    task automatic write_step(int addr, logic [8:0] data);
        @(negedge clk);
        wif.wr_valid = 1'b1;
        wif.wr_addr  = 4'(addr);
        wif.wr_data  = data;
        for (int b = 0; b < 8 && !wif.wr_ready; b++) @(negedge clk);
        chk("idle_ready", wif.wr_ready, 1);
        @(negedge clk);
        wif.wr_valid = 1'b0;
        model_pat[addr] = data;
    endtask

    // Plays n steps from step 0; optionally rewrites the playing step wk
    // while holding wr_valid across its LOAD cycle.
    task automatic play(int sc, int gc, int n, int wk, logic [8:0] wdata);
        int     l;
        int     g;
        int     ph;
        longint e_edge;
        longint stop_at;
        exp_t   e;
        l = step_len(sc);
        g = gate_len(gc, l);
        @(negedge clk);
        step_cycles = 32'(sc);
        gate_cycles = 32'(gc);
        run = 1'b1;
        e_edge = cyc + 1;
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = k % 16;
            if (wk >= 0 && k == wk + 1) model_pat[wk % 16] = wdata;
            if (model_pat[idx][8]) begin
                e.cyc = e_edge + 1 + longint'(k) * l;
                e.wp  = tone_period(model_pat[idx]);
                e.idx = 4'(idx);
                e.g   = g;
                sb.push_back(e);
                exp_wp = e.wp;
            end
        end
        stop_at = e_edge + longint'(n - 1) * l + l / 2;
        ph = (wk >= 0) ? 0 : 3;
        for (int b = 0; b < n * l + 10; b++) begin
            @(negedge clk);
            if (cyc == e_edge) begin
                chk("busy_load", busy, 1);
                chk("ready_load", wif.wr_ready, 0);
            end
            case (ph)
                0: if (cyc == e_edge + longint'(wk) * l) begin
                    wif.wr_valid = 1'b1;
                    wif.wr_addr  = 4'(wk % 16);
                    wif.wr_data  = wdata;
                    chk("ready_hold", wif.wr_ready, 0);
                    ph = 1;
                end
                1: begin
                    chk("ready_accept", wif.wr_ready, 1);
                    ph = 2;
                end
                2: begin
                    wif.wr_valid = 1'b0;
                    ph = 3;
                end
                default: ;
            endcase
            if (cyc == stop_at) begin
                run = 1'b0;
                break;
            end
        end
        wif.wr_valid = 1'b0;
        if (run) begin
            chk("stop_reached", cyc, stop_at);
            run = 1'b0;
        end
        for (int b = 0; b < l + 4; b++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("stop_cycle", cyc, e_edge + longint'(n) * l);
        chk("idle_busy", busy, 0);
        chk("idle_idx", step_idx, 0);
        chk("idle_gate", gate, 0);
        chk("hold_period", wave_period, exp_wp);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        longint e_edge;
        exp_t   e;
        logic [8:0] wd;
        wif.wr_valid = 1'b0;
        wif.wr_addr  = '0;
        wif.wr_data  = '0;
        exp_wp = '0;
        for (int i = 0; i < 16; i++) model_pat[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("rst_trig", trig, 0);
        chk("rst_gate", gate, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", step_idx, 0);
        chk("rst_period", wave_period, 0);
        chk("rst_ready", wif.wr_ready, 1);

        write_step(0, {1'b1, 4'd5, 4'd2});
        play(10, 4, 1, -1, '0);
        chk("period_336", wave_period, 336);

        write_step(0, 9'd0);
        write_step(15, {1'b1, 4'd0, 4'd0});
        play(8, 3, 36, -1, '0);
        chk("period_64", wave_period, 64);

        for (int i = 0; i < 16; i++) write_step(i, {1'b1, 8'($urandom)});
        play(0, 100, 40, -1, '0);

        for (int i = 0; i < 16; i++) write_step(i, {1'b1, 8'($urandom)});
        wd = model_pat[1] ^ 9'h011;
        play(4, 2, 18, 1, wd);

        repeat (6) begin
            repeat (6) write_step(int'($urandom_range(0, 15)), 9'($urandom));
            play(int'($urandom_range(0, 20)), int'($urandom_range(0, 25)),
                 int'($urandom_range(1, 24)), -1, '0);
        end

        // Reset in the middle of step 1's PLAY phase.
        for (int i = 0; i < 16; i++) write_step(i, {1'b1, 8'($urandom)});
        @(negedge clk);
        step_cycles = 32'd5;
        gate_cycles = 32'd3;
        run = 1'b1;
        e_edge = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            e.cyc = e_edge + 1 + longint'(k) * 5;
            e.wp  = tone_period(model_pat[k]);
            e.idx = 4'(k);
            e.g   = 3;
            sb.push_back(e);
        end
        for (int b = 0; b < 20 && cyc != e_edge + 7; b++) @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk("mrst_trig", trig, 0);
        chk("mrst_gate", gate, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_idx", step_idx, 0);
        chk("mrst_period", wave_period, 0);
        chk("mrst_ready", wif.wr_ready, 1);
        chk("mrst_sb", sb.size(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) model_pat[i] = '0;
        exp_wp = '0;
        play(3, 1, 20, -1, '0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
